// File: rtl/nes_pad_pkg.sv
// rtl/nes_pad_pkg.sv - FSM state type, NES/SNES button bit positions and frame latency helper
package nes_pad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_COMMIT   = 3'd4
    } pad_state_e;

    // Positions after MSB-first shifting: the first serial bit lands in the MSB.
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    localparam int SNES_B      = 15;
    localparam int SNES_Y      = 14;
    localparam int SNES_SELECT = 13;
    localparam int SNES_START  = 12;
    localparam int SNES_UP     = 11;
    localparam int SNES_DOWN   = 10;
    localparam int SNES_LEFT   = 9;
    localparam int SNES_RIGHT  = 8;
    localparam int SNES_A      = 7;
    localparam int SNES_X      = 6;
    localparam int SNES_L      = 5;
    localparam int SNES_R      = 4;

    function automatic int frame_latency(input int half_period, input int pad_bits);
        return 2 * half_period + pad_bits * 2 * half_period + 1;
    endfunction

endpackage

// File: rtl/nes_pad_channel.sv
// rtl/nes_pad_channel.sv - per-pad shift register, held button state and edge flags
// Optional NESPAD_DEBOUNCE_EN: accept a frame only when it repeats the previous raw sample.
module nes_pad_channel
    import nes_pad_pkg::*;
#(
    parameter int PAD_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                sample_i,
    input  logic                commit_i,
    input  logic                data_i,
    output logic [PAD_BITS-1:0] buttons_o,
    output logic [PAD_BITS-1:0] pressed_o,
    output logic [PAD_BITS-1:0] released_o
);

    logic [PAD_BITS-1:0] shift_q, shift_d;
    logic [PAD_BITS-1:0] btn_q, btn_d;
    logic [PAD_BITS-1:0] pressed_q, pressed_d;
    logic [PAD_BITS-1:0] released_q, released_d;
    logic                accept;

`ifdef NESPAD_DEBOUNCE_EN
    logic [PAD_BITS-1:0] raw_q, raw_d;

    assign accept = (shift_q == raw_q);

    always_comb begin
        raw_d = raw_q;
        if (commit_i) raw_d = shift_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) raw_q <= '0;
        else       raw_q <= raw_d;
    end
`else
    assign accept = 1'b1;
`endif

    // Pad lines are active-low; store pressed as 1.
    always_comb begin
        shift_d    = shift_q;
        btn_d      = btn_q;
        pressed_d  = '0;
        released_d = '0;
        if (clear_i)       shift_d = '0;
        else if (sample_i) shift_d = PAD_BITS'({shift_q, ~data_i});
        if (commit_i && accept) begin
            btn_d      = shift_q;
            pressed_d  = shift_q & ~btn_q;
            released_d = ~shift_q & btn_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q    <= '0;
            btn_q      <= '0;
            pressed_q  <= '0;
            released_q <= '0;
        end else begin
            shift_q    <= shift_d;
            btn_q      <= btn_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign buttons_o  = btn_q;
    assign pressed_o  = pressed_q;
    assign released_o = released_q;

endmodule

// File: rtl/nes_pad_array.sv
// rtl/nes_pad_array.sv - shared latch/clock timing and frame FSM for NUM_PADS serial pads
// Optional NESPAD_DEBOUNCE_EN enables two-frame agreement inside each nes_pad_channel.
module nes_pad_array
    import nes_pad_pkg::*;
#(
    parameter int NUM_PADS     = 2,
    parameter int PAD_BITS     = 8,
    parameter int HALF_PERIOD  = 256,
    parameter int FRAME_CYCLES = 2**20,
    parameter int AUTO_POLL    = 1
) (
    input  logic                         clk48,
    input  logic                         reset,
    input  logic                         poll_req,
    input  logic [NUM_PADS-1:0]          pad_data,
    output logic                         pad_latch,
    output logic                         pad_clk,
    output logic [NUM_PADS*PAD_BITS-1:0] buttons,
    output logic [NUM_PADS*PAD_BITS-1:0] pressed,
    output logic [NUM_PADS*PAD_BITS-1:0] released,
    output logic                         frame_valid,
    output logic                         busy
);

    localparam int LATENCY = frame_latency(HALF_PERIOD, PAD_BITS);
    localparam int CW = $clog2(2 * HALF_PERIOD);
    localparam int BW = (PAD_BITS > 1) ? $clog2(PAD_BITS) : 1;
    localparam int TW = $clog2(FRAME_CYCLES);

    localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(PAD_BITS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_CYCLES - 1);

    generate
        if (NUM_PADS == 0 || PAD_BITS == 0 || HALF_PERIOD == 0) begin : g_bad_size
            $error("nes_pad_array: NUM_PADS, PAD_BITS and HALF_PERIOD must be non-zero");
        end
        if (FRAME_CYCLES <= LATENCY + 1) begin : g_bad_frame
            $error("nes_pad_array: FRAME_CYCLES too short for one frame");
        end
    endgenerate

    pad_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          start, half_done, last_bit;
    logic          clear, sample, commit;

    assign start     = (AUTO_POLL != 0) ? (timer_q == TIMER_LAST) : poll_req;
    assign half_done = (cnt_q == HALF_LAST);
    assign last_bit  = (bit_q == BIT_LAST);

    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_LATCH;
            ST_LATCH:    if (cnt_q == LATCH_LAST) state_d = ST_SHIFT_LO;
            ST_SHIFT_LO: if (half_done) state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: if (half_done) state_d = last_bit ? ST_COMMIT : ST_SHIFT_LO;
            ST_COMMIT:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pad_latch   = (state_q == ST_LATCH);
        pad_clk     = (state_q == ST_SHIFT_HI);
        busy        = (state_q != ST_IDLE);
        frame_valid = (state_q == ST_COMMIT);
        clear       = (state_q == ST_IDLE) && start;
        sample      = (state_q == ST_SHIFT_LO) && half_done;
        // Channels register the result at the edge entering COMMIT so it is visible with frame_valid.
        commit      = (state_q == ST_SHIFT_HI) && half_done && last_bit;
    end

    // The frame timer free-runs regardless of FSM state; an expiry while busy is simply missed.
    always_comb begin
        cnt_d = ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : cnt_q + CW'(1);
        bit_d = bit_q;
        if (state_q == ST_IDLE)
            bit_d = '0;
        else if ((state_q == ST_SHIFT_HI) && half_done)
            bit_d = last_bit ? '0 : bit_q + BW'(1);
        timer_d = (timer_q == TIMER_LAST) ? '0 : timer_q + TW'(1);
    end

    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            timer_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            timer_q <= timer_d;
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        nes_pad_channel #(
            .PAD_BITS (PAD_BITS)
        ) u_chan (
            .clk_i      (clk48),
            .rst_i      (reset),
            .clear_i    (clear),
            .sample_i   (sample),
            .commit_i   (commit),
            .data_i     (pad_data[p]),
            .buttons_o  (buttons[p*PAD_BITS +: PAD_BITS]),
            .pressed_o  (pressed[p*PAD_BITS +: PAD_BITS]),
            .released_o (released[p*PAD_BITS +: PAD_BITS])
        );
    end

endmodule

// File: tb/tb_nes_pad_array.sv
// tb/tb_nes_pad_array.sv - randomized self-checking bench: manual-poll NES and auto-poll SNES configurations
`timescale 1ns/1ps
module tb_nes_pad_array;

    localparam int HP   = 4;
    localparam int NP0  = 2;
    localparam int PB0  = 8;
    localparam int FC0  = 1024;
    localparam int NP1  = 4;
    localparam int PB1  = 16;
    localparam int FC1  = 200;
    localparam int LAT0 = 2 * HP + PB0 * 2 * HP + 1;
    localparam int LAT1 = 2 * HP + PB1 * 2 * HP + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst0 = 1'b1, rst1 = 1'b1, poll0 = 1'b0, poll1 = 1'b0;
    logic [NP0-1:0]        pad_data0;
    logic                  pad_latch0, pad_clk0, fv0, busy0;
    logic [NP0*PB0-1:0]    buttons0, pressed0, released0;
    logic [NP1-1:0]        pad_data1;
    logic                  pad_latch1, pad_clk1, fv1, busy1;
    logic [NP1*PB1-1:0]    buttons1, pressed1, released1;

    nes_pad_array #(
        .NUM_PADS(NP0), .PAD_BITS(PB0), .HALF_PERIOD(HP), .FRAME_CYCLES(FC0), .AUTO_POLL(0)
    ) u_dut0 (
        .clk48(clk), .reset(rst0), .poll_req(poll0), .pad_data(pad_data0),
        .pad_latch(pad_latch0), .pad_clk(pad_clk0), .buttons(buttons0), .pressed(pressed0),
        .released(released0), .frame_valid(fv0), .busy(busy0)
    );

    nes_pad_array #(
        .NUM_PADS(NP1), .PAD_BITS(PB1), .HALF_PERIOD(HP), .FRAME_CYCLES(FC1), .AUTO_POLL(1)
    ) u_dut1 (
        .clk48(clk), .reset(rst1), .poll_req(poll1), .pad_data(pad_data1),
        .pad_latch(pad_latch1), .pad_clk(pad_clk1), .buttons(buttons1), .pressed(pressed1),
        .released(released1), .frame_valid(fv1), .busy(busy1)
    );

    // Behavioural controllers: latch reloads bit 0, each pad_clk rise advances one bit.
    logic [7:0]  mask0 [NP0];
    logic [15:0] mask1 [NP1];
    int idx0 = 0, idx1 = 0;

    always @(posedge pad_clk0 or posedge pad_latch0)
        if (pad_latch0) idx0 <= 0; else idx0 <= idx0 + 1;
    always @(posedge pad_clk1 or posedge pad_latch1)
        if (pad_latch1) idx1 <= 0; else idx1 <= idx1 + 1;

    always_comb begin
        pad_data0 = '1;
        pad_data1 = '1;
        for (int p = 0; p < NP0; p++) if (idx0 < PB0) pad_data0[p] = ~mask0[p][PB0-1-idx0];
        for (int p = 0; p < NP1; p++) if (idx1 < PB1) pad_data1[p] = ~mask1[p][PB1-1-idx1];
    end

    int checks = 0, failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: slots 0..1 are dut0 pads, 2..5 are dut1 pads.
    logic [15:0] mdl_btn [6];
    logic [15:0] mdl_raw [6];

    task automatic mdl_commit(input int slot, input logic [15:0] s,
                              output logic [15:0] b, output logic [15:0] pr, output logic [15:0] rl);
        bit take;
`ifdef NESPAD_DEBOUNCE_EN
        take = (s == mdl_raw[slot]);
`else
        take = 1'b1;
`endif
        mdl_raw[slot] = s;
        if (take) begin
            pr = s & ~mdl_btn[slot];
            rl = ~s & mdl_btn[slot];
            mdl_btn[slot] = s;
        end else begin
            pr = '0;
            rl = '0;
        end
        b = mdl_btn[slot];
    endtask

    task automatic frame0(input logic [7:0] a, input logic [7:0] b, input bit spam, input string tag);
        int fv_n = 0, fv_at = -1, latch_n = 0, clk_n = 0, busy_n = 0, busy_first = -1, stray = 0;
        logic prev_clk = 1'b0;
        logic [15:0] cb = '0, cp = '0, cr = '0;
        logic [15:0] b0, p0, r0, b1, p1, r1;
        mask0[0] = a;
        mask0[1] = b;
        @(negedge clk);
        poll0 = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            poll0 = spam && (c == 10 || c == 40);
            if (pad_latch0) latch_n++;
            if (pad_clk0 && !prev_clk) clk_n++;
            prev_clk = pad_clk0;
            if (busy0) begin
                busy_n++;
                if (busy_first < 0) busy_first = c;
            end
            if (fv0) begin
                fv_n++;
                fv_at = c;
                cb = buttons0; cp = pressed0; cr = released0;
            end else if (pressed0 != '0 || released0 != '0) begin
                stray++;
            end
        end
        poll0 = 1'b0;
        mdl_commit(0, {8'h00, a}, b0, p0, r0);
        mdl_commit(1, {8'h00, b}, b1, p1, r1);
        check_eq({tag, "_fv_count"},   fv_n, 1);
        check_eq({tag, "_fv_cycle"},   fv_at, LAT0);
        check_eq({tag, "_latch_len"},  latch_n, 2 * HP);
        check_eq({tag, "_clk_pulses"}, clk_n, PB0);
        check_eq({tag, "_busy_len"},   busy_n, LAT0);
        check_eq({tag, "_busy_first"}, busy_first, 1);
        check_eq({tag, "_stray_flags"}, stray, 0);
        check_eq({tag, "_buttons"},    cb, {b1[7:0], b0[7:0]});
        check_eq({tag, "_pressed"},    cp, {p1[7:0], p0[7:0]});
        check_eq({tag, "_released"},   cr, {r1[7:0], r0[7:0]});
        check_eq({tag, "_held"},       buttons0, {b1[7:0], b0[7:0]});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] ra, rb;
        int rises, hit, bad;
        logic prev;

        for (int i = 0; i < 6; i++) begin mdl_btn[i] = '0; mdl_raw[i] = '0; end
        for (int p = 0; p < NP0; p++) mask0[p] = '0;
        for (int p = 0; p < NP1; p++) mask1[p] = 16'($urandom);

        repeat (3) @(negedge clk);
        check_eq("rst_dut0_outs", {pad_latch0, pad_clk0, fv0, busy0}, 4'b0);
        check_eq("rst_dut0_vecs", {buttons0, pressed0, released0}, '0);
        check_eq("rst_dut1_outs", {pad_latch1, pad_clk1, fv1, busy1}, 4'b0);
        check_eq("rst_dut1_btn",  buttons1, '0);
        rst0 = 1'b0;
        repeat (2) @(negedge clk);

        frame0(8'h81, 8'h00, 1'b0, "single");
        frame0(8'h81, 8'h10, 1'b1, "press_spam");
        frame0(8'h81, 8'h00, 1'b0, "release");
        frame0(8'h01, 8'h00, 1'b0, "deb1");
        frame0(8'h02, 8'h00, 1'b0, "deb2");
        frame0(8'h02, 8'h00, 1'b0, "deb3");

        ra = 8'($urandom);
        rb = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(1, 0) == 0) begin ra = 8'($urandom); rb = 8'($urandom); end
            frame0(ra, rb, i == 2, $sformatf("rnd%0d", i));
        end

        // Abort a frame during SHIFT_HI of bit 3 (the fourth pad_clk pulse).
        mask0[0] = 8'($urandom);
        mask0[1] = 8'($urandom);
        @(negedge clk);
        poll0 = 1'b1;
        rises = 0; hit = 0; prev = 1'b0; bad = 0;
        for (int c = 0; c < 200 && hit == 0; c++) begin
            @(negedge clk);
            poll0 = 1'b0;
            if (fv0) bad++;
            if (pad_clk0 && !prev) rises++;
            prev = pad_clk0;
            if (rises == 4) hit = 1;
        end
        check_eq("abort_reached_bit3", hit, 1);
        rst0 = 1'b1;
        #1;
        check_eq("abort_outs", {pad_latch0, pad_clk0, fv0, busy0}, 4'b0);
        check_eq("abort_vecs", {buttons0, pressed0, released0}, '0);
        repeat (4) begin
            @(negedge clk);
            if (fv0 || busy0) bad++;
        end
        check_eq("abort_no_fv", bad, 0);
        rst0 = 1'b0;
        mdl_btn[0] = '0; mdl_btn[1] = '0; mdl_raw[0] = '0; mdl_raw[1] = '0;
        repeat (2) @(negedge clk);
        frame0(8'($urandom), 8'($urandom), 1'b0, "post_rst");

        // Auto-poll SNES array: frames every FC1 cycles counted from reset release.
        begin
            int nfr = 0, clk_n = 0, latch_n = 0;
            logic pc = 1'b0;
            logic [63:0] eb, ep, er;
            logic [15:0] b, pr, rl;
            @(negedge clk);
            rst1 = 1'b0;
            for (int c = 1; c <= 1300 && nfr < 5; c++) begin
                @(negedge clk);
                if (pad_latch1) latch_n++;
                if (pad_clk1 && !pc) clk_n++;
                pc = pad_clk1;
                if (fv1) begin
                    check_eq($sformatf("auto_fv_cycle%0d", nfr), c, FC1 + LAT1 - 1 + nfr * FC1);
                    check_eq($sformatf("auto_clk_pulses%0d", nfr), clk_n, PB1);
                    check_eq($sformatf("auto_latch_len%0d", nfr), latch_n, 2 * HP);
                    for (int p = 0; p < NP1; p++) begin
                        mdl_commit(2 + p, mask1[p], b, pr, rl);
                        eb[p*16 +: 16] = b;
                        ep[p*16 +: 16] = pr;
                        er[p*16 +: 16] = rl;
                    end
                    check_eq($sformatf("auto_buttons%0d", nfr), buttons1, eb);
                    check_eq($sformatf("auto_pressed%0d", nfr), pressed1, ep);
                    check_eq($sformatf("auto_released%0d", nfr), released1, er);
                    for (int p = 0; p < NP1; p++)
                        if ($urandom_range(1, 0) == 0) mask1[p] = 16'($urandom);
                    clk_n = 0;
                    latch_n = 0;
                    nfr++;
                end
            end
            check_eq("auto_frames", nfr, 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
